// File: rtl/tcm_arb_pick.sv
// 2-way winner picker for tcm_arbiter: bit 0 is the I port, bit 1 the D port.
// prio_d_i breaks a tie in favour of D; tie it high for fixed priority.
module tcm_arb_pick (
    input  logic [1:0] req_i,
    input  logic       prio_d_i,
    output logic       gnt_vld_o,
    output logic       gnt_d_o
);

    assign gnt_vld_o = |req_i;
    assign gnt_d_o   = req_i[1] & (~req_i[0] | prio_d_i);

endmodule

// File: rtl/tcm_arbiter.sv
// Arbitrates the I and D ports onto one TCM port; widths follow femto.vh.
// Define TCM_ARB_RR_EN for round-robin ties, otherwise D has fixed priority.
`ifndef TCM_VA_WIDTH
`define TCM_VA_WIDTH 16
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif

module tcm_arbiter (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [`TCM_VA_WIDTH-1:0]  i_addr,
    input  logic                      i_w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] i_acc,
    input  logic [`BUS_WIDTH-1:0]     i_wdata,
    input  logic                      i_req,
    output logic [`BUS_WIDTH-1:0]     i_rdata,
    output logic                      i_resp,
    output logic                      i_fault,
    input  logic [`TCM_VA_WIDTH-1:0]  d_addr,
    input  logic                      d_w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] d_acc,
    input  logic [`BUS_WIDTH-1:0]     d_wdata,
    input  logic                      d_req,
    output logic [`BUS_WIDTH-1:0]     d_rdata,
    output logic                      d_resp,
    output logic                      d_fault,
    output logic [`TCM_VA_WIDTH-1:0]  t_addr,
    output logic                      t_w_rb,
    output logic [`BUS_ACC_WIDTH-1:0] t_acc,
    output logic [`BUS_WIDTH-1:0]     t_wdata,
    output logic                      t_req,
    input  logic [`BUS_WIDTH-1:0]     t_rdata,
    input  logic                      t_resp,
    input  logic                      t_fault
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
    localparam logic       OWN_I   = 1'b0;
    localparam logic       OWN_D   = 1'b1;

    logic [0:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic [1:0] elig;
    logic       win_vld, win_d, prio_d;
    logic       resp_cyc, stall, accept;
    logic       own_i_resp, own_d_resp;

    // A WAIT without t_resp keeps the port busy; the resp cycle frees it.
    assign resp_cyc   = (state_q == ST_WAIT) & t_resp;
    assign stall      = (state_q == ST_WAIT) & ~t_resp;
    assign own_i_resp = resp_cyc & (owner_q == OWN_I);
    assign own_d_resp = resp_cyc & (owner_q == OWN_D);

    assign elig[0] = i_req & ~stall & ~own_i_resp;
    assign elig[1] = d_req & ~stall & ~own_d_resp;

`ifdef TCM_ARB_RR_EN
    logic rr_q, rr_d;

    assign prio_d = rr_q;
    assign rr_d   = accept ? ~win_d : rr_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign prio_d = 1'b1;
`endif

    tcm_arb_pick u_pick (
        .req_i     (elig),
        .prio_d_i  (prio_d),
        .gnt_vld_o (win_vld),
        .gnt_d_o   (win_d)
    );

    assign t_req   = win_vld & rstn;
    assign t_addr  = win_d ? d_addr  : i_addr;
    assign t_w_rb  = win_d ? d_w_rb  : i_w_rb;
    assign t_acc   = win_d ? d_acc   : i_acc;
    assign t_wdata = win_d ? d_wdata : i_wdata;
    assign accept  = t_req & ~t_fault;

    assign i_fault = t_req & t_fault & ~win_d;
    assign d_fault = t_req & t_fault & win_d;
    assign i_resp  = rstn & own_i_resp;
    assign d_resp  = rstn & own_d_resp;
    assign i_rdata = i_resp ? t_rdata : '0;
    assign d_rdata = d_resp ? t_rdata : '0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (accept) begin
            state_d = ST_WAIT;
            owner_d = win_d ? OWN_D : OWN_I;
        end else if (resp_cyc) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_I;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_tcm_arbiter.sv
// Bench for tcm_arbiter: vector table, corner sequences, random vs model.
// Built with or without TCM_ARB_RR_EN; expectations follow the macro.
`ifndef TCM_VA_WIDTH
`define TCM_VA_WIDTH 16
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tb_tcm_arbiter;

`ifdef TCM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] i_addr, d_addr, t_addr;
    logic        i_w_rb, d_w_rb, t_w_rb;
    logic [1:0]  i_acc, d_acc, t_acc;
    logic [31:0] i_wdata, d_wdata, t_wdata;
    logic        i_req, d_req, t_req;
    logic [31:0] i_rdata, d_rdata, t_rdata;
    logic        i_resp, d_resp, t_resp;
    logic        i_fault, d_fault, t_fault;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] tcm_mem [0:255];
    logic [7:0] ref_mem [0:255];

    always #5 clk = ~clk;

    tcm_arbiter dut (
        .clk(clk), .rstn(rstn),
        .i_addr(i_addr), .i_w_rb(i_w_rb), .i_acc(i_acc),
        .i_wdata(i_wdata), .i_req(i_req), .i_rdata(i_rdata),
        .i_resp(i_resp), .i_fault(i_fault),
        .d_addr(d_addr), .d_w_rb(d_w_rb), .d_acc(d_acc),
        .d_wdata(d_wdata), .d_req(d_req), .d_rdata(d_rdata),
        .d_resp(d_resp), .d_fault(d_fault),
        .t_addr(t_addr), .t_w_rb(t_w_rb), .t_acc(t_acc),
        .t_wdata(t_wdata), .t_req(t_req), .t_rdata(t_rdata),
        .t_resp(t_resp), .t_fault(t_fault)
    );

    function automatic int nb(input logic [1:0] acc);
        return (acc == `BUS_ACC_1B) ? 1 : (acc == `BUS_ACC_2B) ? 2 : 4;
    endfunction

    function automatic bit misal(input logic [1:0] acc, input logic [1:0] a);
        return (acc == `BUS_ACC_2B && a[0]) || (acc == `BUS_ACC_4B && a != 2'd0);
    endfunction

    function automatic logic [31:0] mrd(input bit use_ref, input logic [7:0] a,
                                        input logic [1:0] acc);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < 4; k++)
            if (k < nb(acc))
                v[8*k+:8] = use_ref ? ref_mem[8'(a + 8'(k))] : tcm_mem[8'(a + 8'(k))];
        return v;
    endfunction

    // TCM model: misaligned accesses fault at once, others answer next cycle.
    always_comb t_fault = t_req && misal(t_acc, t_addr[1:0]);

    initial begin
        t_resp  = 1'b0;
        t_rdata = '0;
        for (int k = 0; k < 256; k++) tcm_mem[k] = 8'h00;
        tcm_mem[8'h10] = 8'hEF;
        tcm_mem[8'h11] = 8'hBE;
        tcm_mem[8'h12] = 8'hAD;
        tcm_mem[8'h13] = 8'hDE;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                t_resp <= 1'b0;
            end else begin
                t_resp <= t_req && !t_fault;
                if (t_req && !t_fault) begin
                    if (t_w_rb) begin
                        for (int k = 0; k < nb(t_acc); k++)
                            tcm_mem[8'(t_addr[7:0] + 8'(k))] = t_wdata[8*k+:8];
                        t_rdata <= '0;
                    end else begin
                        t_rdata <= mrd(1'b0, t_addr[7:0], t_acc);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_i(input bit r, input logic [15:0] a, input bit w,
                         input logic [1:0] acc, input logic [31:0] wd);
        i_req = r; i_addr = a; i_w_rb = w; i_acc = acc; i_wdata = wd;
    endtask

    task automatic set_d(input bit r, input logic [15:0] a, input bit w,
                         input logic [1:0] acc, input logic [31:0] wd);
        d_req = r; d_addr = a; d_w_rb = w; d_acc = acc; d_wdata = wd;
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        nxt();
        @(negedge clk);
        chk("rst_treq", 32'(t_req), 0);
        chk("rst_resp", {30'd0, i_resp, d_resp}, 0);
        chk("rst_fault", {30'd0, i_fault, d_fault}, 0);
        nxt();
        rstn = 1'b1;
    endtask

    typedef struct {
        string       nm;
        bit          ir;
        logic [15:0] ia;
        logic [1:0]  iacc;
        bit          dr;
        logic [15:0] da;
        logic [1:0]  dacc;
        bit          dw;
        bit          e_treq;
        logic [15:0] e_taddr;
        bit          e_if;
        bit          e_df;
    } vec_t;

    vec_t tbl [8];

    bit          m_busy, m_own, m_last, i_done, d_done;
    bit          ei, ed, has, wd, flt, ww;
    logic [15:0] waddr;
    logic [1:0]  wacc;
    logic [31:0] wwd, m_edata;
    logic [15:0] exp_seq [4];

    initial begin
        rstn = 1'b0;
        set_i(0, 0, 0, 0, 0);
        set_d(0, 0, 0, 0, 0);

        tbl[0] = '{"i_rd",      1, 16'h10, `BUS_ACC_4B, 0, 16'h00, `BUS_ACC_4B, 0,
                   1, 16'h10, 0, 0};
        tbl[1] = '{"d_wr",      0, 16'h00, `BUS_ACC_4B, 1, 16'h20, `BUS_ACC_4B, 1,
                   1, 16'h20, 0, 0};
        tbl[2] = '{"d_misal2",  0, 16'h00, `BUS_ACC_4B, 1, 16'h01, `BUS_ACC_2B, 1,
                   1, 16'h01, 0, 1};
        tbl[3] = '{"i_misal4",  1, 16'h02, `BUS_ACC_4B, 0, 16'h00, `BUS_ACC_4B, 0,
                   1, 16'h02, 1, 0};
        tbl[4] = '{"both",      1, 16'h30, `BUS_ACC_4B, 1, 16'h40, `BUS_ACC_4B, 0,
                   1, RR ? 16'h30 : 16'h40, 0, 0};
        tbl[5] = '{"both_dmis", 1, 16'h30, `BUS_ACC_4B, 1, 16'h41, `BUS_ACC_2B, 0,
                   1, RR ? 16'h30 : 16'h41, 0, !RR};
        tbl[6] = '{"none",      0, 16'h30, `BUS_ACC_4B, 0, 16'h40, `BUS_ACC_4B, 0,
                   0, 16'h00, 0, 0};
        tbl[7] = '{"i_byte",    1, 16'h07, `BUS_ACC_1B, 0, 16'h00, `BUS_ACC_4B, 0,
                   1, 16'h07, 0, 0};

        for (int v = 0; v < 8; v++) begin
            reset_dut();
            set_i(tbl[v].ir, tbl[v].ia, 1'b0, tbl[v].iacc, 32'h0);
            set_d(tbl[v].dr, tbl[v].da, tbl[v].dw, tbl[v].dacc, 32'h1234_5678);
            @(negedge clk);
            chk({tbl[v].nm, "_treq"}, 32'(t_req), 32'(tbl[v].e_treq));
            if (tbl[v].e_treq) chk({tbl[v].nm, "_taddr"}, 32'(t_addr), 32'(tbl[v].e_taddr));
            chk({tbl[v].nm, "_ifault"}, 32'(i_fault), 32'(tbl[v].e_if));
            chk({tbl[v].nm, "_dfault"}, 32'(d_fault), 32'(tbl[v].e_df));
            chk({tbl[v].nm, "_resp"}, {30'd0, i_resp, d_resp}, 0);
            nxt();
            i_req = 1'b0;
            d_req = 1'b0;
            nxt();
            nxt();
        end

        // Single I read.
        reset_dut();
        set_i(1, 16'h10, 0, `BUS_ACC_4B, 0);
        @(negedge clk);
        chk("rd_c0_treq", 32'(t_req), 1);
        chk("rd_c0_resp", {30'd0, i_resp, d_resp}, 0);
        nxt();
        @(negedge clk);
        chk("rd_c1_iresp", 32'(i_resp), 1);
        chk("rd_c1_rdata", i_rdata, 32'hDEADBEEF);
        chk("rd_c1_dresp", 32'(d_resp), 0);
        chk("rd_c1_drdata", d_rdata, 0);
        chk("rd_c1_treq", 32'(t_req), 0);
        nxt();
        i_req = 1'b0;
        nxt();

        // Contention with both requests held.
        reset_dut();
        set_i(1, 16'h30, 0, `BUS_ACC_4B, 0);
        set_d(1, 16'h40, 0, `BUS_ACC_4B, 0);
        for (int c = 0; c < 4; c++)
            exp_seq[c] = (RR ^ (c % 2 == 1)) ? 16'h30 : 16'h40;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("cont_c%0d_taddr", c), 32'(t_addr), 32'(exp_seq[c]));
            chk($sformatf("cont_c%0d_treq", c), 32'(t_req), 1);
            if (c > 0)
                chk($sformatf("cont_c%0d_resp", c), {30'd0, i_resp, d_resp},
                    (exp_seq[c-1] == 16'h30) ? 32'd2 : 32'd1);
            nxt();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        nxt();
        nxt();

        // Fault then immediate I acceptance.
        reset_dut();
        set_d(1, 16'h01, 1, `BUS_ACC_2B, 32'h0000_BEEF);
        @(negedge clk);
        chk("flt_dfault", 32'(d_fault), 1);
        chk("flt_ifault", 32'(i_fault), 0);
        chk("flt_dresp", 32'(d_resp), 0);
        nxt();
        d_req = 1'b0;
        set_i(1, 16'h10, 0, `BUS_ACC_4B, 0);
        @(negedge clk);
        chk("flt_i_treq", 32'(t_req), 1);
        chk("flt_i_taddr", 32'(t_addr), 32'h10);
        chk("flt_dresp2", 32'(d_resp), 0);
        nxt();
        @(negedge clk);
        chk("flt_i_resp", 32'(i_resp), 1);
        chk("flt_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("flt_dresp3", 32'(d_resp), 0);
        nxt();
        i_req = 1'b0;
        nxt();

        // Owner masking with i_req held 3 cycles.
        reset_dut();
        set_i(1, 16'h10, 0, `BUS_ACC_4B, 0);
        @(negedge clk);
        chk("msk_c0_treq", 32'(t_req), 1);
        nxt();
        @(negedge clk);
        chk("msk_c1_treq", 32'(t_req), 0);
        chk("msk_c1_iresp", 32'(i_resp), 1);
        nxt();
        @(negedge clk);
        chk("msk_c2_treq", 32'(t_req), 1);
        chk("msk_c2_iresp", 32'(i_resp), 0);
        nxt();
        i_req = 1'b0;
        @(negedge clk);
        chk("msk_c3_iresp", 32'(i_resp), 1);
        chk("msk_c3_treq", 32'(t_req), 0);
        nxt();
        @(negedge clk);
        chk("msk_c4_iresp", 32'(i_resp), 0);
        nxt();

        // Reset asserted in the WAIT cycle.
        reset_dut();
        set_i(1, 16'h10, 0, `BUS_ACC_4B, 0);
        @(negedge clk);
        chk("rmid_c0_treq", 32'(t_req), 1);
        nxt();
        rstn = 1'b0;
        @(negedge clk);
        chk("rmid_resp", {30'd0, i_resp, d_resp}, 0);
        chk("rmid_treq", 32'(t_req), 0);
        nxt();
        i_req = 1'b0;
        nxt();
        rstn = 1'b1;
        @(negedge clk);
        chk("rmid_post_resp", {30'd0, i_resp, d_resp}, 0);
        nxt();
        set_d(1, 16'h03, 1, `BUS_ACC_1B, 32'h0000_00A5);
        @(negedge clk);
        chk("rmid_wr_treq", 32'(t_req), 1);
        chk("rmid_wr_fault", 32'(d_fault), 0);
        chk("rmid_wr_iresp", 32'(i_resp), 0);
        nxt();
        @(negedge clk);
        chk("rmid_wr_dresp", 32'(d_resp), 1);
        nxt();
        set_d(1, 16'h03, 0, `BUS_ACC_1B, 0);
        @(negedge clk);
        chk("rmid_rd_treq", 32'(t_req), 1);
        nxt();
        @(negedge clk);
        chk("rmid_rd_dresp", 32'(d_resp), 1);
        chk("rmid_rd_data", d_rdata, 32'h0000_00A5);
        nxt();
        d_req = 1'b0;
        nxt();

        // Random traffic against a transaction-level model.
        reset_dut();
        for (int k = 0; k < 256; k++) ref_mem[k] = tcm_mem[k];
        m_busy  = 1'b0;
        m_own   = 1'b0;
        m_last  = 1'b1;
        m_edata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            ei  = i_req && !(m_busy && !m_own);
            ed  = d_req && !(m_busy && m_own);
            has = ei || ed;
            wd  = ed && (!ei || (RR ? !m_last : 1'b1));
            waddr = wd ? d_addr : i_addr;
            wacc  = wd ? d_acc : i_acc;
            ww    = wd ? d_w_rb : i_w_rb;
            wwd   = wd ? d_wdata : i_wdata;
            flt   = has && misal(wacc, waddr[1:0]);
            chk("rnd_treq", 32'(t_req), 32'(has));
            if (has) chk("rnd_taddr", 32'(t_addr), 32'(waddr));
            if (has) chk("rnd_twrb", 32'(t_w_rb), 32'(ww));
            chk("rnd_ifault", 32'(i_fault), 32'(flt && !wd));
            chk("rnd_dfault", 32'(d_fault), 32'(flt && wd));
            chk("rnd_iresp", 32'(i_resp), 32'(m_busy && !m_own));
            chk("rnd_dresp", 32'(d_resp), 32'(m_busy && m_own));
            chk("rnd_irdata", i_rdata, (m_busy && !m_own) ? m_edata : 32'h0);
            chk("rnd_drdata", d_rdata, (m_busy && m_own) ? m_edata : 32'h0);
            i_done = (m_busy && !m_own) || (flt && !wd);
            d_done = (m_busy && m_own) || (flt && wd);
            if (has && !flt) begin
                m_busy = 1'b1;
                m_own  = wd;
                m_last = wd;
                if (ww) begin
                    for (int k = 0; k < nb(wacc); k++)
                        ref_mem[8'(waddr[7:0] + 8'(k))] = wwd[8*k+:8];
                    m_edata = '0;
                end else begin
                    m_edata = mrd(1'b1, waddr[7:0], wacc);
                end
            end else begin
                m_busy = 1'b0;
            end
            nxt();
            if (!(i_req && !i_done)) begin
                if ($urandom_range(0, 99) < 60)
                    set_i(1, 16'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 2)), $urandom());
                else
                    i_req = 1'b0;
            end
            if (!(d_req && !d_done)) begin
                if ($urandom_range(0, 99) < 60)
                    set_d(1, 16'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 2)), $urandom());
                else
                    d_req = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
